// File: rtl/hockey_core_param.sv
// Parametrised air-hockey game controller. The puck travels between player A (column 0)
// and player B (column X_MAX). It reflects off the top and bottom rows. A player
// returns the puck by pressing their button while their paddle row matches the puck row.
// A match ends when one player reaches WIN_SCORE; the scores are then cleared
// automatically.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   BTN_A, BTN_B         debounced level buttons
//   DIR_A, DIR_B         launch direction: 01 up (+Y), 10 down (-Y), 00/11 straight
//   Y_in_A, Y_in_B       paddle rows
//   X_COORD, Y_COORD     puck position
//   SCORE_A, SCORE_B     points
//   STATE_OUT            encoded FSM state
//   WINNER               00 none, 01 A, 10 B
module hockey_core_param #(
  parameter int unsigned X_MAX      = 4,
  parameter int unsigned Y_MAX      = 4,
  parameter int unsigned XW         = 3,
  parameter int unsigned YW         = 3,
  parameter int unsigned WIN_SCORE  = 3,
  parameter int unsigned SW         = 2,
  parameter int unsigned STEP_TICKS = 2,
  parameter int unsigned RESP_TICKS = 2,
  parameter int unsigned DISP_TICKS = 2,
  parameter int unsigned SPEEDUP    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          BTN_A,
  input  logic          BTN_B,
  input  logic [1:0]    DIR_A,
  input  logic [1:0]    DIR_B,
  input  logic [YW-1:0] Y_in_A,
  input  logic [YW-1:0] Y_in_B,
  output logic [XW-1:0] X_COORD,
  output logic [YW-1:0] Y_COORD,
  output logic [SW-1:0] SCORE_A,
  output logic [SW-1:0] SCORE_B,
  output logic [3:0]    STATE_OUT,
  output logic [1:0]    WINNER
);

  localparam int unsigned TMax0 = (STEP_TICKS > RESP_TICKS) ? STEP_TICKS : RESP_TICKS;
  localparam int unsigned TMax  = (TMax0 > DISP_TICKS) ? TMax0 : DISP_TICKS;
  localparam int unsigned TW    = $clog2(TMax + 1);

  localparam logic [XW-1:0] XLast    = XW'(X_MAX);
  localparam logic [YW-1:0] YLast    = YW'(Y_MAX);
  localparam logic [TW-1:0] StepInit = TW'(STEP_TICKS);
  localparam logic [TW-1:0] RespLast = TW'(RESP_TICKS - 1);
  localparam logic [TW-1:0] DispLast = TW'(DISP_TICKS - 1);
  localparam logic [SW-1:0] WinPts   = SW'(WIN_SCORE);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StDisplay  = 4'd1,
    StHitA     = 4'd2,
    StHitB     = 4'd3,
    StSendA    = 4'd4,
    StSendB    = 4'd5,
    StRespA    = 4'd6,
    StRespB    = 4'd7,
    StGoalA    = 4'd8,
    StGoalB    = 4'd9,
    StGameOver = 4'd10
  } state_e;

  state_e        state_q;
  logic          server_b_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [1:0]    dir_q;
  logic [TW-1:0] step_q;
  logic [TW-1:0] timer_q;
  logic [SW-1:0] score_a_q;
  logic [SW-1:0] score_b_q;
  logic [1:0]    winner_q;

  logic [XW-1:0] x_inc;
  logic [XW-1:0] x_dec;
  logic [TW-1:0] step_dec;
  logic          step_due;

  // One vertical step with reflection; returns {new_dir, new_y}.
  function automatic logic [YW+1:0] y_move(input logic [YW-1:0] y, input logic [1:0] d);
    logic [YW+1:0] r;
    r = {d, y};
    case (d)
      2'b01:   r = (y >= YLast) ? {2'b10, y - YW'(1)} : {2'b01, y + YW'(1)};
      2'b10:   r = (y == '0) ? {2'b01, y + YW'(1)} : {2'b10, y - YW'(1)};
      default: r = {d, y};
    endcase
    return r;
  endfunction

  always_comb begin
    x_inc    = x_q + XW'(1);
    x_dec    = x_q - XW'(1);
    step_due = (timer_q == step_q - TW'(1));
    step_dec = ((SPEEDUP != 0) && (step_q > TW'(1))) ? step_q - TW'(1) : step_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      server_b_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      dir_q      <= '0;
      step_q     <= '0;
      timer_q    <= '0;
      score_a_q  <= '0;
      score_b_q  <= '0;
      winner_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (BTN_A || BTN_B) begin
            server_b_q <= !BTN_A;  // A has priority when both press
            winner_q   <= '0;
            timer_q    <= '0;
            state_q    <= StDisplay;
          end
        end
        StDisplay: begin
          if (timer_q == DispLast) begin
            timer_q <= '0;
            state_q <= server_b_q ? StHitB : StHitA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StHitA: begin
          if (BTN_A && (Y_in_A <= YLast)) begin
            x_q     <= '0;
            y_q     <= Y_in_A;
            dir_q   <= DIR_A;
            step_q  <= StepInit;
            timer_q <= '0;
            state_q <= StSendB;
          end
        end
        StHitB: begin
          if (BTN_B && (Y_in_B <= YLast)) begin
            x_q     <= XLast;
            y_q     <= Y_in_B;
            dir_q   <= DIR_B;
            step_q  <= StepInit;
            timer_q <= '0;
            state_q <= StSendA;
          end
        end
        StSendB: begin
          if (step_due) begin
            timer_q      <= '0;
            x_q          <= x_inc;
            {dir_q, y_q} <= y_move(y_q, dir_q);
            if (x_inc == XLast) state_q <= StRespB;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StSendA: begin
          if (step_due) begin
            timer_q      <= '0;
            x_q          <= x_dec;
            {dir_q, y_q} <= y_move(y_q, dir_q);
            if (x_dec == '0) state_q <= StRespA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StRespB: begin
          if (BTN_B && (Y_in_B == y_q)) begin
            x_q          <= XLast - XW'(1);
            {dir_q, y_q} <= y_move(y_q, DIR_B);
            step_q       <= step_dec;
            timer_q      <= '0;
            state_q      <= StSendA;
          end else if (timer_q == RespLast) begin
            timer_q   <= '0;
            score_a_q <= (score_a_q < WinPts) ? score_a_q + SW'(1) : score_a_q;
            state_q   <= StGoalA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StRespA: begin
          if (BTN_A && (Y_in_A == y_q)) begin
            x_q          <= XW'(1);
            {dir_q, y_q} <= y_move(y_q, DIR_A);
            step_q       <= step_dec;
            timer_q      <= '0;
            state_q      <= StSendB;
          end else if (timer_q == RespLast) begin
            timer_q   <= '0;
            score_b_q <= (score_b_q < WinPts) ? score_b_q + SW'(1) : score_b_q;
            state_q   <= StGoalB;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StGoalA: begin
          if (timer_q == DispLast) begin
            timer_q <= '0;
            if (score_a_q == WinPts) begin
              winner_q <= 2'b01;
              state_q  <= StGameOver;
            end else begin
              state_q <= StHitB;  // conceding player serves
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StGoalB: begin
          if (timer_q == DispLast) begin
            timer_q <= '0;
            if (score_b_q == WinPts) begin
              winner_q <= 2'b10;
              state_q  <= StGameOver;
            end else begin
              state_q <= StHitA;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StGameOver: begin
          if (timer_q == DispLast) begin
            timer_q   <= '0;
            score_a_q <= '0;
            score_b_q <= '0;
            state_q   <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign X_COORD   = x_q;
  assign Y_COORD   = y_q;
  assign SCORE_A   = score_a_q;
  assign SCORE_B   = score_b_q;
  assign STATE_OUT = state_q;
  assign WINNER    = winner_q;

endmodule

// File: tb/tb_hockey_core_param.sv
// Directed bench: default-parameter instance plays serve/bounce/miss/return/match-end
// sequences; a second instance with a larger field checks reflection at row 6,
// constant speed and a 5-point match.
module tb_hockey_core_param;

  logic       clk;
  logic       rst;
  logic       btn_a, btn_b;
  logic [1:0] dir_a, dir_b;
  logic [2:0] y_in_a, y_in_b;
  logic [2:0] x1, y1;
  logic [1:0] sa1, sb1;
  logic [3:0] st1;
  logic [1:0] win1;

  logic       btn_a2, btn_b2;
  logic [1:0] dir_a2, dir_b2;
  logic [2:0] y_in_a2, y_in_b2;
  logic [2:0] x2, y2, sa2, sb2;
  logic [3:0] st2;
  logic [1:0] win2;

  int n_checks = 0;
  int n_fail   = 0;

  int xs1[4] = '{1, 2, 3, 4};
  int ys1[4] = '{3, 4, 3, 2};
  int xs2[7] = '{1, 2, 3, 4, 5, 6, 7};
  int ys2[7] = '{6, 5, 4, 3, 2, 1, 0};

  hockey_core_param dut (
    .clk(clk), .rst(rst), .BTN_A(btn_a), .BTN_B(btn_b), .DIR_A(dir_a), .DIR_B(dir_b),
    .Y_in_A(y_in_a), .Y_in_B(y_in_b), .X_COORD(x1), .Y_COORD(y1), .SCORE_A(sa1),
    .SCORE_B(sb1), .STATE_OUT(st1), .WINNER(win1)
  );

  hockey_core_param #(
    .X_MAX(7), .Y_MAX(6), .XW(3), .YW(3), .WIN_SCORE(5), .SW(3), .SPEEDUP(0)
  ) dut2 (
    .clk(clk), .rst(rst), .BTN_A(btn_a2), .BTN_B(btn_b2), .DIR_A(dir_a2), .DIR_B(dir_b2),
    .Y_in_A(y_in_a2), .Y_in_B(y_in_b2), .X_COORD(x2), .Y_COORD(y2), .SCORE_A(sa2),
    .SCORE_B(sb2), .STATE_OUT(st2), .WINNER(win2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_st1(input logic [3:0] target, input string tag);
    int n = 0;
    while (st1 !== target && n < 200) begin
      tick();
      n++;
    end
    check(tag, st1, target);
  endtask

  task automatic wait_st2(input logic [3:0] target, input string tag);
    int n = 0;
    while (st2 !== target && n < 200) begin
      tick();
      n++;
    end
    check(tag, st2, target);
  endtask

  initial begin
    rst = 1'b0;
    btn_a = 0; btn_b = 0; dir_a = 0; dir_b = 0; y_in_a = 0; y_in_b = 0;
    btn_a2 = 0; btn_b2 = 0; dir_a2 = 0; dir_b2 = 0; y_in_a2 = 0; y_in_b2 = 0;

    // Reset
    tick(); tick(); tick();
    check("rst_state", st1, 0);
    rst = 1'b1;
    tick();
    check("post_rst_state", st1, 0);
    check("post_rst_x", x1, 0);
    check("post_rst_y", y1, 0);
    check("post_rst_sa", sa1, 0);
    check("post_rst_sb", sb1, 0);
    check("post_rst_win", win1, 0);

    // Both buttons in IDLE: A serves
    btn_a = 1; btn_b = 1;
    tick();
    check("display_1", st1, 1);
    btn_a = 0; btn_b = 0;
    tick();
    check("display_2", st1, 1);
    tick();
    check("hit_a_after_both", st1, 2);

    // Out-of-range paddle ignored
    y_in_a = 6; btn_a = 1;
    tick();
    check("bad_row_stays", st1, 2);

    // Serve and bounce
    y_in_a = 2; dir_a = 2'b01;
    tick();
    btn_a = 0;
    check("serve_state", st1, 5);
    check("serve_x", x1, 0);
    check("serve_y", y1, 2);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("hold_x_%0d", k), x1, k);
      tick();
      check($sformatf("bounce_x_%0d", k), x1, xs1[k]);
      check($sformatf("bounce_y_%0d", k), y1, ys1[k]);
    end
    check("resp_b_entry", st1, 7);

    // Miss by B
    tick();
    check("resp_b_window", st1, 7);
    tick();
    check("goal_a_state", st1, 8);
    check("goal_a_score", sa1, 1);
    tick();
    check("goal_a_hold", st1, 8);
    tick();
    check("hit_b_after_goal", st1, 3);

    // B serves straight, A returns (speed-up), B returns down
    btn_b = 1; y_in_b = 1; dir_b = 2'b00;
    tick();
    btn_b = 0;
    check("b_serve_state", st1, 4);
    check("b_serve_x", x1, 4);
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      check($sformatf("send_a_x_%0d", k), x1, 3 - k);
      check($sformatf("send_a_y_%0d", k), y1, 1);
    end
    check("resp_a_entry", st1, 6);
    btn_a = 1; y_in_a = 1; dir_a = 2'b00;
    tick();
    btn_a = 0;
    check("a_return_state", st1, 5);
    check("a_return_x", x1, 1);
    tick();
    check("fast_x2", x1, 2);
    tick();
    check("fast_x3", x1, 3);
    tick();
    check("fast_x4", x1, 4);
    check("fast_resp_b", st1, 7);
    btn_b = 1; y_in_b = 1; dir_b = 2'b10;
    tick();
    btn_b = 0;
    check("b_return_state", st1, 4);
    check("b_return_x", x1, 3);
    check("b_return_y", y1, 0);
    tick();
    check("refl0_x", x1, 2);
    check("refl0_y", y1, 1);
    tick();
    check("up_x", x1, 1);
    check("up_y", y1, 2);
    tick();
    check("resp_a_2", st1, 6);
    tick(); tick();
    check("goal_b_state", st1, 9);
    check("goal_b_score", sb1, 1);
    check("score_a_kept", sa1, 1);
    tick(); tick();
    check("hit_a_after_goal_b", st1, 2);

    // Mid-game asynchronous reset
    btn_a = 1; y_in_a = 2; dir_a = 2'b01;
    tick();
    btn_a = 0;
    tick(); tick();
    check("pre_rst_x", x1, 1);
    rst = 1'b0;
    #1;
    check("async_rst_state", st1, 0);
    check("async_rst_x", x1, 0);
    check("async_rst_y", y1, 0);
    check("async_rst_sa", sa1, 0);
    check("async_rst_sb", sb1, 0);
    tick();
    rst = 1'b1;
    tick();
    check("after_rst_idle", st1, 0);

    // Match: three A points
    btn_a = 1;
    tick();
    btn_a = 0;
    wait_st1(2, "m_hit_a");
    btn_a = 1; y_in_a = 0; dir_a = 2'b00;
    tick();
    btn_a = 0;
    wait_st1(7, "m_p1_resp_b");
    wait_st1(8, "m_p1_goal");
    check("m_p1_score", sa1, 1);
    wait_st1(3, "m_p1_hit_b");
    for (int p = 2; p <= 3; p++) begin
      btn_b = 1; y_in_b = 0; dir_b = 2'b00;
      tick();
      btn_b = 0;
      wait_st1(6, $sformatf("m_p%0d_resp_a", p));
      btn_a = 1; y_in_a = 0; dir_a = 2'b00;
      tick();
      btn_a = 0;
      check($sformatf("m_p%0d_return", p), st1, 5);
      wait_st1(7, $sformatf("m_p%0d_resp_b", p));
      wait_st1(8, $sformatf("m_p%0d_goal", p));
      check($sformatf("m_p%0d_score", p), sa1, p);
      if (p == 2) wait_st1(3, "m_p2_hit_b");
    end
    tick(); tick();
    check("game_over_state", st1, 10);
    check("game_over_winner", win1, 1);
    tick();
    check("game_over_hold", st1, 10);
    tick();
    check("go_idle", st1, 0);
    check("go_sa_clear", sa1, 0);
    check("go_sb_clear", sb1, 0);
    check("go_winner_held", win1, 1);
    btn_b = 1;
    tick();
    btn_b = 0;
    check("new_display", st1, 1);
    check("winner_cleared", win1, 0);
    tick(); tick();
    check("b_server_hit", st1, 3);

    // Larger field, no speed-up, 5-point match
    btn_a2 = 1;
    tick();
    btn_a2 = 0;
    wait_st2(2, "d2_hit_a");
    btn_a2 = 1; y_in_a2 = 5; dir_a2 = 2'b01;
    tick();
    btn_a2 = 0;
    check("d2_serve_y", y2, 5);
    for (int k = 0; k < 7; k++) begin
      tick(); tick();
      check($sformatf("d2_x_%0d", k), x2, xs2[k]);
      check($sformatf("d2_y_%0d", k), y2, ys2[k]);
    end
    check("d2_resp_b", st2, 7);
    btn_b2 = 1; y_in_b2 = 0; dir_b2 = 2'b00;
    tick();
    btn_b2 = 0;
    check("d2_ret_x", x2, 6);
    tick();
    check("d2_const_hold", x2, 6);
    tick();
    check("d2_const_step", x2, 5);
    wait_st2(9, "d2_goal_b1");
    check("d2_sb1", sb2, 1);
    wait_st2(2, "d2_hit_a1");
    for (int p = 2; p <= 5; p++) begin
      btn_a2 = 1; y_in_a2 = 0; dir_a2 = 2'b00;
      tick();
      btn_a2 = 0;
      wait_st2(7, $sformatf("d2_p%0d_resp_b", p));
      btn_b2 = 1; y_in_b2 = 0;
      tick();
      btn_b2 = 0;
      check($sformatf("d2_p%0d_return", p), st2, 4);
      wait_st2(9, $sformatf("d2_p%0d_goal", p));
      check($sformatf("d2_p%0d_score", p), sb2, p);
      if (p < 5) wait_st2(2, $sformatf("d2_p%0d_hit_a", p));
    end
    tick(); tick();
    check("d2_game_over", st2, 10);
    check("d2_winner", win2, 2);
    tick(); tick();
    check("d2_idle", st2, 0);
    check("d2_sb_clear", sb2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hockey_core_param.md
Name: hockey_core_param

Overview:
- Parametrised successor to the fixed-size air-hockey game FSM.
- Field size, score limit, step/response/display timing and puck speed-up are all parameters.
- Adds score, state and winner outputs, corrects the return-direction handling, and clears the match automatically after game over.
- Sits between the button/switch debouncers and the LED/SSD display driver.

Parameters:
- X_MAX, 4: last X column. A owns column 0, B owns column X_MAX.
- Y_MAX, 4: last Y row. Rows are 0..Y_MAX.
- XW, 3: X coordinate width. Must hold X_MAX.
- YW, 3: Y coordinate width. Must hold Y_MAX.
- WIN_SCORE, 3: points needed to win.
- SW, 2: score width. Must hold WIN_SCORE.
- STEP_TICKS, 2: clk cycles per puck step at serve speed (≥1).
- RESP_TICKS, 2: clk cycles in the return window (≥1).
- DISP_TICKS, 2: clk cycles spent in DISPLAY, GOAL_x and GAME_OVER (≥1).
- SPEEDUP, 1: 1 = step interval shrinks by 1 on each successful return (floor 1). 0 = constant speed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- BTN_A  in  1  player A button, debounced, level
- BTN_B  in  1  player B button, debounced, level
- DIR_A  in  2  A direction: 00 straight, 01 up (+Y), 10 down (−Y), 11 straight
- DIR_B  in  2  B direction, same encoding as DIR_A
- Y_in_A  in  YW  A paddle row
- Y_in_B  in  YW  B paddle row
- X_COORD  out  XW  puck column
- Y_COORD  out  YW  puck row
- SCORE_A  out  SW  A points
- SCORE_B  out  SW  B points
- STATE_OUT  out  4  encoded FSM state
- WINNER  out  2  00 none, 01 A, 10 B

Behaviour:
- Reset: clk and rst only; rst is asynchronous, active-low.
  - While rst=0, all outputs are 0, STATE_OUT=IDLE, and timer, dir and step register clear.
  - A mid-game reset takes effect immediately, without waiting for a clock edge.
- State encoding on STATE_OUT: IDLE=0, DISPLAY=1, HIT_A=2, HIT_B=3, SEND_A=4, SEND_B=5, RESP_A=6, RESP_B=7, GOAL_A=8, GOAL_B=9, GAME_OVER=10.
- Outputs are registered. Every change appears on the clk edge that makes the decision.
- IDLE:
  - BTN_A → DISPLAY with server=A. Otherwise BTN_B → DISPLAY with server=B.
  - If both are pressed, A wins.
  - Entering DISPLAY clears WINNER.
- DISPLAY: stay DISP_TICKS cycles, then go to HIT_(server).
- HIT_A:
  - Serve fires on BTN_A=1 with Y_in_A ≤ Y_MAX.
  - On serve: X←0, Y←Y_in_A, dir←DIR_A, step←STEP_TICKS, → SEND_B.
  - Y_in_A > Y_MAX is ignored; FSM stays in HIT_A.
- HIT_B: mirror of HIT_A with X←X_MAX, → SEND_A.
- SEND_B: the puck moves once every `step` cycles.
  - X←X+1.
  - Y moves per dir with reflection: up at Y_MAX sets dir=down and Y−1; down at 0 sets dir=up and Y+1; straight holds Y.
  - When the new X equals X_MAX, → RESP_B.
- SEND_A: mirror of SEND_B with X←X−1, → RESP_A when the new X is 0.
- RESP_B: window of RESP_TICKS cycles starting on entry.
  - Hit: BTN_B=1 and Y_in_B==Y_COORD in any window cycle.
    - X←X_MAX−1, dir←DIR_B, one Y step applied with reflection.
    - If SPEEDUP, step←max(step−1,1).
    - Timer clears, → SEND_A.
  - Window expires: SCORE_A+1, → GOAL_A.
- RESP_A: mirror of RESP_B.
  - Hit sets X←1, dir←DIR_A, → SEND_B.
  - Miss sets SCORE_B+1, → GOAL_B.
  - The returning player's own DIR always sets the direction.
- GOAL_A: hold DISP_TICKS cycles.
  - If SCORE_A==WIN_SCORE: WINNER←01, → GAME_OVER.
  - Otherwise → HIT_B (the conceding player serves).
- GOAL_B: mirror of GOAL_A (WINNER←10, else → HIT_A).
- GAME_OVER: hold DISP_TICKS cycles, then clear scores and → IDLE. WINNER holds until the next DISPLAY.
- Scores never exceed WIN_SCORE. No wrap is possible.
- Unused state encodings → IDLE on the next edge.
- Buttons are level-sensitive: a button held through the HIT/RESP entry counts immediately.

Test Plan:
- Reset: hold rst=0 for 3 clk, release → all outputs 0, STATE_OUT=0. Pull rst=0 mid-SEND_B → outputs are 0 before the next edge.
- Serve and bounce, defaults: BTN_A in IDLE → 2 cycles in DISPLAY, then HIT_A. Serve with Y_in_A=2, DIR_A=01 → (X,Y) sequence (0,2),(1,3),(2,4),(3,3),(4,2), 2 cycles apart, then STATE_OUT=7.
- Miss: no BTN_B in RESP_B for 2 cycles → SCORE_A=1, STATE_OUT=8 for 2 cycles, then 3 (HIT_B).
- Return with speed-up: in RESP_B press BTN_B with Y_in_B=Y_COORD and DIR_B=10 → X=3, Y decremented, STATE_OUT=4. Subsequent X steps occur every 1 cycle.
- Match end: three consecutive A points → WINNER=01, STATE_OUT=10 for 2 cycles, then IDLE with SCORE_A=SCORE_B=0. WINNER clears when the next serve enters DISPLAY.
- Edge cases:
  - Y_in_A=6 with BTN_A in HIT_A → stays in HIT_A.
  - BTN_A and BTN_B pressed together in IDLE → A serves.
  - Re-run with X_MAX=7, Y_MAX=6, WIN_SCORE=5, SPEEDUP=0 → reflection at row 6, constant step rate, game over at 5 points.
